// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and types for the I/D memory request arbiter.
package mem_req_arbiter_pkg;

    localparam logic       OWNER_I   = 1'b0;
    localparam logic       OWNER_D   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Which requester, if any, is mid-handshake with the downstream port.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_I    = 2'd1,
        LOCK_D    = 2'd2
    } lock_state_e;

    // Lock state that pins the given owner until its addr_ok.
    function automatic lock_state_e lock_of(input logic owner);
        return (owner == OWNER_D) ? LOCK_D : LOCK_I;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Fetch, load/store and downstream memory handshakes of the arbiter.
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok;
    logic              i_data_ok;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [STRB_W-1:0] d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_wr;
    logic [1:0]        m_size;
    logic [STRB_W-1:0] m_wstrb;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_addr_ok;
    logic              m_data_ok;
    logic [DATA_W-1:0] m_rdata;

    logic              proto_err;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr,
        output i_addr_ok, i_data_ok, i_rdata,
        input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output proto_err
    );

    // Requesters plus downstream memory.
    modport master (
        output i_req, i_addr,
        input  i_addr_ok, i_data_ok, i_rdata,
        output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  proto_err
    );

endinterface

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order record of which requester owns each outstanding transaction.
module mem_owner_fifo #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             head,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign cnt       = cnt_q;
    assign head      = mem_q[rd_ptr_q];
    // A full FIFO still takes a push in the cycle its head leaves.
    assign push_ok_c = push & (~full | pop);
    assign pop_ok_c  = pop & ~empty;

    // Storage, wrapping pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one split-transaction memory port between fetch (I) and load/store (D).
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    mem_req_arbiter_if.slave  bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT) + 1;

    lock_state_e       state_q;
    lock_state_e       state_d;
    logic              grant_vld_c;
    logic              grant_id_c;
    logic              grant_req_c;
    logic              grant_d_c;
    logic              m_req_c;
    logic              accept_c;
    logic              pop_c;
    logic [ADDR_W-1:0] addr_sel_c;
    logic              fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              proto_err_q;

    // Lock state register; reset discards any half-done handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= LOCK_NONE;
        else         state_q <= state_d;
    end

    // Grant selection, downstream request qualification and lock transitions.
    always_comb begin
        state_d     = state_q;
        grant_vld_c = 1'b0;
        grant_id_c  = OWNER_I;
        case (state_q)
            LOCK_I: begin
                grant_vld_c = 1'b1;
                grant_id_c  = OWNER_I;
            end
            LOCK_D: begin
                grant_vld_c = 1'b1;
                grant_id_c  = OWNER_D;
            end
            default: begin
                if (bus.d_req) begin
                    grant_vld_c = 1'b1;
                    grant_id_c  = OWNER_D;
                end else if (bus.i_req) begin
                    grant_vld_c = 1'b1;
                    grant_id_c  = OWNER_I;
                end
            end
        endcase
        grant_req_c = (grant_id_c == OWNER_D) ? bus.d_req : bus.i_req;
        m_req_c     = resetn & grant_vld_c & grant_req_c & ~fifo_full;
        accept_c    = m_req_c & bus.m_addr_ok;
        if (accept_c)      state_d = LOCK_NONE;
        else if (m_req_c)  state_d = lock_of(grant_id_c);
    end

    assign grant_d_c  = grant_vld_c & (grant_id_c == OWNER_D);
    assign addr_sel_c = grant_d_c ? bus.d_addr : bus.i_addr;

    assign bus.m_req   = m_req_c;
    assign bus.m_wr    = grant_d_c & bus.d_wr;
    assign bus.m_size  = grant_d_c ? bus.d_size  : SIZE_WORD;
    assign bus.m_wstrb = grant_d_c ? bus.d_wstrb : STRB_W'(0);
    assign bus.m_addr  = addr_sel_c;
    assign bus.m_wdata = grant_d_c ? bus.d_wdata : DATA_W'(0);

    assign bus.i_addr_ok = accept_c & (grant_id_c == OWNER_I);
    assign bus.d_addr_ok = accept_c & (grant_id_c == OWNER_D);

    // Responses are in order, so the FIFO head always names the owner.
    assign pop_c         = resetn & bus.m_data_ok & ~fifo_empty;
    assign bus.i_data_ok = pop_c & (fifo_head == OWNER_I);
    assign bus.d_data_ok = pop_c & (fifo_head == OWNER_D);
    assign bus.i_rdata   = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;

    mem_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept_c),
        .pop    (pop_c),
        .din    (grant_id_c),
        .head   (fifo_head),
        .cnt    (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky flag for a response that nobody is waiting for.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  proto_err_q <= 1'b0;
        else if (bus.m_data_ok && (fifo_cnt == '0))   proto_err_q <= 1'b1;
    end

    assign bus.proto_err = proto_err_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares one downstream SRAM-like memory port between the CPU's instruction-fetch requester (port I) and load/store requester (port D). It uses request/addr_ok/data_ok split-transaction handshakes on both sides.
- Picks a requester each cycle and forwards its request unchanged.
- Records the owner of every accepted transaction in order.
- Routes each returning data_ok/rdata to the correct requester.
- Sits between the pipeline's fetch/memory stages and the external memory bridge.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_OUT, 2, maximum outstanding (address-accepted, data-not-returned) transactions; power of 2, >=1

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request valid
i_addr  in  ADDR_W  fetch address
i_addr_ok  out  1  fetch request accepted this cycle
i_data_ok  out  1  fetch data returned this cycle
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request valid
d_wr  in  1  1=store, 0=load
d_size  in  2  0=byte, 1=half, 2=word
d_wstrb  in  DATA_W/8  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_addr_ok  out  1  data request accepted this cycle
d_data_ok  out  1  data response (load data or store ack) this cycle
d_rdata  out  DATA_W  load data
m_req  out  1  downstream request valid
m_wr  out  1  downstream write flag
m_size  out  2  downstream size
m_wstrb  out  DATA_W/8  downstream byte enables
m_addr  out  ADDR_W  downstream address
m_wdata  out  DATA_W  downstream write data
m_addr_ok  in  1  downstream accepted request
m_data_ok  in  1  downstream response valid
m_rdata  in  DATA_W  downstream read data
proto_err  out  1  sticky: m_data_ok seen with no outstanding transaction

Behaviour:
- Reset values: lock_vld=0, owner FIFO empty (cnt=0), proto_err=0. While resetn=0, m_req, i_addr_ok, d_addr_ok, i_data_ok and d_data_ok are forced to 0.
- Requester rule: a requester holds req and all request fields stable from assertion until its addr_ok. The arbiter does not check this.
- Grant selection (combinational):
  - If lock_vld=1, grant=lock_id.
  - Else if d_req=1, grant=D (data has fixed priority).
  - Else if i_req=1, grant=I.
  - Else no grant.
- m_req = granted requester's req & (cnt != MAX_OUT). When the FIFO is full, no request is forwarded; lock state is unaffected.
- Request fields for grant=I: m_addr=i_addr, m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
- Request fields for grant=D: all m_* fields come from the d_* inputs.
- Lock: if m_req=1 and m_addr_ok=0 at a clock edge, set lock_vld=1 and lock_id=grant. Clear lock_vld on the edge where m_addr_ok=1. A request already presented downstream is never switched mid-handshake, even if d_req rises while I is locked.
- Address acceptance: x_addr_ok = m_req & m_addr_ok & (grant==x). Zero-cycle combinational path. On that edge, push grant (0=I, 1=D) into the owner FIFO.
- Data return: on m_data_ok with cnt>0, pop the FIFO head and assert the head owner's data_ok in the same cycle (combinational).
  - i_rdata and d_rdata both equal m_rdata at all times.
  - Responses return strictly in acceptance order; the downstream port is in-order.
- Simultaneous push and pop in one cycle: cnt is unchanged, head advances, tail advances. This is legal at any cnt, including cnt=MAX_OUT-1 and cnt=MAX_OUT. At cnt=MAX_OUT no push occurs anyway, because m_req=0.
- Pointer wrap: read and write pointers are log2(MAX_OUT) bits wide and wrap modulo MAX_OUT. cnt is log2(MAX_OUT)+1 bits wide.
- m_data_ok with cnt=0: no data_ok is asserted, no pop occurs, and proto_err sets and stays 1 until reset.
- m_addr_ok while m_req=0: ignored.
- Reset mid-operation: outstanding ownership and lock are discarded immediately. The downstream memory must be reset by the same resetn.

Decomposition:
- constants.h gets OWNER_I=1'b0, OWNER_D=1'b1, and SIZE_WORD=2'd2.
- One natural sub-module: mem_owner_fifo. It is a 1-bit-wide, MAX_OUT-deep synchronous FIFO with push, pop, head, cnt, full and empty, using the same clk and async resetn.

Test Plan:
- i_req=1 at 0x1c000000, m_addr_ok=1 the same cycle, m_data_ok after 2 cycles with m_rdata=0x02800c0c -> i_addr_ok=1 in cycle 0; i_data_ok=1 with i_rdata=0x02800c0c in cycle 2; d_* outputs stay 0.
- i_req and d_req (load 0x1c001000) both asserted with m_addr_ok=1 -> D granted first, m_addr=0x1c001000; I granted the next cycle; two data_ok pulses return D then I.
- i_req=1 with m_addr_ok held 0 for 3 cycles, d_req rising in cycle 1 -> m_addr stays the I address for all 3 cycles; D is granted only after I's addr_ok.
- MAX_OUT=2: two requests accepted with no m_data_ok -> cnt=2, m_req=0 with d_req=1; one m_data_ok -> the next cycle m_req=1; a simultaneous accept+return at cnt=1 keeps cnt=1.
- m_data_ok pulse with nothing outstanding -> no data_ok, proto_err=1 and stays 1; resetn low mid-transaction -> proto_err=0, cnt=0, all handshake outputs 0 asynchronously.
